// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: elastic register between two core pipeline stages.
// It is a circular buffer of DEPTH entries with a valid/ready handshake on
// each side and a synchronous flush used to squash wrong-path work.
// in_ready depends only on registered state, so there is no combinational
// path from out_ready to in_ready. An empty buffer has no bypass: data
// accepted at a clock edge appears on out_data after that edge.
module pipe_stage_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LW-1:0]    level
);

    localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);
    localparam logic [LW-1:0]   CNT_FULL = LW'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]               count_q, count_d;
    logic                        push, pop;

    // DEPTH need not be a power of two, so wrap by compare.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : PW'(p + 1'b1);
    endfunction

    // Handshake outputs come from registered state only.
    always_comb begin
        in_ready  = (count_q != CNT_FULL);
        out_valid = (count_q != '0);
        out_data  = mem_q[rd_ptr_q];
        level     = count_q;
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
    end

    // Next-state: flush empties the buffer and voids both handshakes.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + LW'(1);
            end else if (pop && !push) begin
                count_d = count_q - LW'(1);
            end
        end
    end

    // State registers; reset clears storage so out_data reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: three instances (DEPTH 2, 3, 1)
// share one clock and reset; each scenario drives one instance.
module tb_pipe_stage_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DEPTH=2 instance
    logic        a_flush = 0, a_in_valid = 0, a_out_ready = 0;
    logic        a_in_ready, a_out_valid;
    logic [31:0] a_in_data = '0, a_out_data;
    logic [1:0]  a_level;
    // DEPTH=3 instance
    logic        b_flush = 0, b_in_valid = 0, b_out_ready = 0;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_in_data = '0, b_out_data;
    logic [1:0]  b_level;
    // DEPTH=1 instance
    logic        c_flush = 0, c_in_valid = 0, c_out_ready = 0;
    logic        c_in_ready, c_out_valid;
    logic [31:0] c_in_data = '0, c_out_data;
    logic [0:0]  c_level;

    int checks = 0;
    int errors = 0;

    pipe_stage_buffer #(.WIDTH(32), .DEPTH(2)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .level(a_level));

    pipe_stage_buffer #(.WIDTH(32), .DEPTH(3)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .level(b_level));

    pipe_stage_buffer #(.WIDTH(32), .DEPTH(1)) u_c (
        .clk(clk), .rst(rst), .flush(c_flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .level(c_level));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one clock edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset state ----
        #1;
        chk("rst_a_out_valid", 32'(a_out_valid), 0);
        chk("rst_a_level",     32'(a_level),     0);
        chk("rst_a_in_ready",  32'(a_in_ready),  1);
        chk("rst_a_out_data",  a_out_data,       0);
        step();
        rst = 1'b0;
        step();

        // ---- async reset mid-stream with 2 entries ----
        a_in_valid = 1; a_in_data = 32'h11; step();
        a_in_data = 32'h22; step();
        a_in_valid = 0;
        chk("mid_pre_level", 32'(a_level), 2);
        rst = 1'b1; #1;
        chk("mid_rst_out_valid", 32'(a_out_valid), 0);
        chk("mid_rst_level",     32'(a_level),     0);
        chk("mid_rst_in_ready",  32'(a_in_ready),  1);
        chk("mid_rst_out_data",  a_out_data,       0);
        step();
        rst = 1'b0;
        step();

        // ---- DEPTH=2 streaming 1..8 with out_ready high ----
        a_out_ready = 1; a_in_valid = 1;
        for (int i = 1; i <= 8; i++) begin
            a_in_data = 32'(i);
            step();
            chk("stream_data",  a_out_data,         32'(i));
            chk("stream_level", 32'(a_level),       1);
            chk("stream_valid", 32'(a_out_valid),   1);
        end
        a_in_valid = 0; step();
        chk("stream_drain_level", 32'(a_level), 0);

        // ---- DEPTH=2 back-pressure ----
        a_out_ready = 0; a_in_valid = 1;
        a_in_data = 32'hA; step();
        chk("bp_level1",   32'(a_level),    1);
        chk("bp_ready1",   32'(a_in_ready), 1);
        a_in_data = 32'hB; step();
        chk("bp_level2",   32'(a_level),    2);
        chk("bp_ready2",   32'(a_in_ready), 0);
        chk("bp_head_a",   a_out_data,      32'hA);
        a_in_data = 32'hC; step();
        chk("bp_hold_lvl", 32'(a_level),    2);
        chk("bp_hold_a",   a_out_data,      32'hA);
        chk("bp_hold_rdy", 32'(a_in_ready), 0);
        a_out_ready = 1; step();
        chk("bp_out_b",    a_out_data,      32'hB);
        chk("bp_lvl_b",    32'(a_level),    1);
        step();
        chk("bp_out_c",    a_out_data,      32'hC);
        chk("bp_lvl_c",    32'(a_level),    1);
        a_in_valid = 0; step();
        chk("bp_empty",    32'(a_out_valid), 0);

        // ---- DEPTH=2 flush with same-cycle input ----
        a_out_ready = 0; a_in_valid = 1;
        a_in_data = 32'h1; step();
        a_in_data = 32'h2; step();
        chk("fl_pre_level", 32'(a_level), 2);
        a_flush = 1; a_in_data = 32'hF; a_out_ready = 1; step();
        chk("fl_level",     32'(a_level),     0);
        chk("fl_valid",     32'(a_out_valid), 0);
        a_flush = 0; a_in_valid = 0; step();
        chk("fl_no_f",      32'(a_out_valid), 0);
        a_in_valid = 1; a_in_data = 32'h5; a_out_ready = 0; step();
        a_in_valid = 0;
        chk("fl_after_data", a_out_data, 32'h5);
        chk("fl_after_lvl",  32'(a_level), 1);

        // ---- DEPTH=3 fill, then simultaneous push/pop across wrap ----
        b_out_ready = 0; b_in_valid = 1;
        for (int i = 1; i <= 3; i++) begin
            b_in_data = 32'(i);
            step();
        end
        b_in_valid = 0;
        chk("d3_full_level", 32'(b_level),    3);
        chk("d3_full_ready", 32'(b_in_ready), 0);
        chk("d3_head",       b_out_data,      1);
        // full: pop only, since in_ready is low
        b_out_ready = 1; step();
        chk("d3_pop_level",  32'(b_level), 2);
        chk("d3_pop_head",   b_out_data,   2);
        b_in_valid = 1;
        for (int k = 0; k < 5; k++) begin
            b_in_data = 32'(4 + k);
            step();
            chk("d3_pp_level", 32'(b_level), 2);
            chk("d3_pp_head",  b_out_data,   32'(3 + k));
        end
        b_in_valid = 0; step();
        chk("d3_drain_head", b_out_data,   8);
        chk("d3_drain_lvl",  32'(b_level), 1);
        step();
        chk("d3_empty",      32'(b_out_valid), 0);

        // ---- DEPTH=1 half throughput ----
        c_out_ready = 1; c_in_valid = 1;
        for (int n = 1; n <= 4; n++) begin
            c_in_data = 32'(n);
            chk("d1_ready_hi",  32'(c_in_ready),  1);
            chk("d1_valid_lo",  32'(c_out_valid), 0);
            step();
            chk("d1_ready_lo",  32'(c_in_ready),  0);
            chk("d1_valid_hi",  32'(c_out_valid), 1);
            chk("d1_data",      c_out_data,       32'(n));
            step();
        end
        c_in_valid = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // hard stop in case the sequence stalls
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
